nrs_gold_seq_writer: RTL and testbench

// - Write side of the NRS bit register: produces the 3GPP 36.211 §7.2 Gold sequence c(n).
// - Computes c(n) = x1(n+Nc) XOR x2(n+Nc) from a 31-bit c_init.
// - Writes WIDTH_REG consecutive bits, one per clock, into the NRS register through its
//   wr_en / wr_addr / c_n port, at addresses 0..WIDTH_REG-1.
// - Lives in the NRS value generator, upstream of the est/fine readers of that register.

---
 rtl/nrs_pkg.sv | 26 ++
 rtl/gold_lfsr_pair.sv | 41 ++++
 rtl/nrs_gold_seq_writer.sv | 107 ++++++++++
 tb/tb_nrs_gold_seq_writer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
`timescale 1ns/1ps
// Shared constants, state encoding and LFSR step helper for the NRS Gold sequence writer.
package nrs_pkg;

    localparam int NC_DEFAULT = 1600;
    localparam int CINIT_W    = 31;

    // A tap mask selects the bits XORed into the new bit30 on each right shift.
    localparam logic [CINIT_W-1:0] X1_TAPS = 31'h9;
    localparam logic [CINIT_W-1:0] X2_TAPS = 31'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    function automatic logic [CINIT_W-1:0] lfsr_step(
        input logic [CINIT_W-1:0] x,
        input logic [CINIT_W-1:0] taps
    );
        return {^(x & taps), x[CINIT_W-1:1]};
    endfunction

endpackage

// File: rtl/gold_lfsr_pair.sv
`timescale 1ns/1ps
// x1/x2 Gold sequence shift registers; bit_o is the current c(n) = x1[0]^x2[0].
module gold_lfsr_pair
    import nrs_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [CINIT_W-1:0] seed_i,
    output logic               bit_o
);

    logic [CINIT_W-1:0] x1_q, x1_d;
    logic [CINIT_W-1:0] x2_q, x2_d;

    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        if (load_i) begin
            x1_d = CINIT_W'(1);
            x2_d = seed_i;
        end else if (step_i) begin
            x1_d = lfsr_step(x1_q, X1_TAPS);
            x2_d = lfsr_step(x2_q, X2_TAPS);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
        end
    end

    assign bit_o = x1_q[0] ^ x2_q[0];

endmodule

// File: rtl/nrs_gold_seq_writer.sv
`timescale 1ns/1ps
// Generates WIDTH_REG Gold sequence bits c(NC)..c(NC+WIDTH_REG-1) and writes them
// into the NRS bit register at addresses 0..WIDTH_REG-1, one per clock.
//
// state   | meaning
// IDLE    | waiting for start; LFSRs loaded on accept
// ADVANCE | discarding the first NC sequence elements
// WRITE   | one register write per cycle, address = cnt
// DONE    | one-cycle done pulse, then back to IDLE
module nrs_gold_seq_writer
    import nrs_pkg::*;
#(
    parameter int WIDTH_REG = 16,
    parameter int LINES     = $clog2(WIDTH_REG),
    parameter int NC        = NC_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CINIT_W-1:0] c_init_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               wr_en_o,
    output logic [LINES-1:0]   wr_addr_o,
    output logic               c_n_o
);

    localparam int CNT_W = ($clog2(NC + 1) > LINES) ? $clog2(NC + 1) : LINES;
    // NC=0 never enters ADVANCE, so its terminal count is a don't-care.
    localparam logic [CNT_W-1:0] ADV_LAST = (NC > 0) ? CNT_W'(NC - 1) : '0;
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WIDTH_REG - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lfsr_load;
    logic             lfsr_step_en;
    logic             lfsr_bit;

    gold_lfsr_pair u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (lfsr_load),
        .step_i (lfsr_step_en),
        .seed_i (c_init_i),
        .bit_o  (lfsr_bit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        wr_en_o      = 1'b0;
        wr_addr_o    = '0;
        c_n_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lfsr_load = 1'b1;
                    cnt_d     = '0;
                    state_d   = (NC > 0) ? ADVANCE : WRITE;
                end
            end
            ADVANCE: begin
                busy_o       = 1'b1;
                lfsr_step_en = 1'b1;
                if (cnt_q == ADV_LAST) begin
                    cnt_d   = '0;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                busy_o       = 1'b1;
                lfsr_step_en = 1'b1;
                wr_en_o      = 1'b1;
                wr_addr_o    = cnt_q[LINES-1:0];
                c_n_o        = lfsr_bit;
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nrs_gold_seq_writer.sv
`timescale 1ns/1ps
// Bench for nrs_gold_seq_writer: one instance with NC=0 and one with NC=1600,
// checked against a Gold sequence model built directly from the x1/x2 recurrences.
module tb_nrs_gold_seq_writer;

    localparam int W   = 16;
    localparam int NC1 = 1600;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic [30:0] cinit_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        wr_en_s [2];
    logic        c_n_s   [2];
    logic [3:0]  addr_s  [2];

    int cyc     = 0;
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nrs_gold_seq_writer #(.WIDTH_REG(W), .NC(0)) u_dut0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start_s[0]),
        .c_init_i  (cinit_s[0]),
        .busy_o    (busy_s[0]),
        .done_o    (done_s[0]),
        .wr_en_o   (wr_en_s[0]),
        .wr_addr_o (addr_s[0]),
        .c_n_o     (c_n_s[0])
    );

    nrs_gold_seq_writer #(.WIDTH_REG(W), .NC(NC1)) u_dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start_s[1]),
        .c_init_i  (cinit_s[1]),
        .busy_o    (busy_s[1]),
        .done_o    (done_s[1]),
        .wr_en_o   (wr_en_s[1]),
        .wr_addr_o (addr_s[1]),
        .c_n_o     (c_n_s[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // c(n) = x1(n+Nc) ^ x2(n+Nc), with x1(n+31) = x1(n+3)+x1(n),
    // x2(n+31) = x2(n+3)+x2(n+2)+x2(n+1)+x2(n), x1(0)=1, x2(i)=c_init bit i.
    function automatic logic [15:0] gold_ref(input logic [30:0] seed, input int nc);
        bit x1 [4200];
        bit x2 [4200];
        logic [15:0] r;
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = seed[i];
        end
        for (int n = 0; n + 31 < nc + W; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int k = 0; k < W; k++) r[k] = x1[nc+k] ^ x2[nc+k];
        return r;
    endfunction

    // Entered just after a negedge with the DUT idle; returns with the DUT idle
    // one cycle after done, so the next call starts back-to-back.
    task automatic run_seq(input int d, input logic [30:0] seed, input int nc,
                           input bit stress, input logic [15:0] exp_img);
        logic [15:0] got_img  = '0;
        int          n_wr     = 0;
        int          n_done   = 0;
        int          t_first  = -1;
        int          a_first  = -1;
        int          a_max    = 0;
        int          t_done   = -1;
        int          t_acc;
        bit          seen     = 0;
        bit          busy_aft = 0;
        int          n_trail;

        start_s[d] = 1'b1;
        cinit_s[d] = seed;
        t_acc      = cyc + 1;
        for (int i = 0; i < nc + W + 8 && !seen; i++) begin
            @(negedge clk); #1;
            if (wr_en_s[d]) begin
                got_img[addr_s[d]] = c_n_s[d];
                n_wr++;
                if (t_first < 0) begin
                    t_first = cyc;
                    a_first = int'(addr_s[d]);
                end
                if (int'(addr_s[d]) > a_max) a_max = int'(addr_s[d]);
            end
            if (done_s[d]) begin
                n_done++;
                t_done = cyc;
                seen   = 1;
            end
            start_s[d] = 1'b0;
            if (stress) begin
                cinit_s[d] = 31'($urandom);
                if (busy_s[d] || done_s[d]) start_s[d] = 1'($urandom_range(0, 1));
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);

        n_trail = stress ? 4 : 1;
        for (int i = 0; i < n_trail; i++) begin
            @(negedge clk); #1;
            start_s[d] = 1'b0;
            if (wr_en_s[d]) n_wr++;
            if (done_s[d]) n_done++;
            if (busy_s[d]) busy_aft = 1;
        end

        check_val("image",     32'(got_img), 32'(exp_img));
        check_val("wr_count",  n_wr, W);
        check_val("done_cnt",  n_done, 1);
        check_val("first_adr", a_first, 0);
        check_val("max_adr",   a_max, W - 1);
        check_val("first_lat", t_first + 1 - t_acc, 1 + nc);
        check_val("done_lat",  t_done + 1 - t_acc, 1 + nc + W);
        if (stress) check_val("idle_after", 32'(busy_aft), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [30:0] seed;
        bit          found;
        int          n_done;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b1;
            cinit_s[d] = 31'($urandom);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++)
            check_val("reset_out", {busy_s[d], done_s[d], wr_en_s[d], addr_s[d], c_n_s[d]}, 32'd0);
        rst = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        @(negedge clk); #1;
        check_val("idle_busy0", 32'(busy_s[0]), 32'd0);
        check_val("idle_busy1", 32'(busy_s[1]), 32'd0);

        // Directed NC=0 seeds, run back-to-back.
        run_seq(0, 31'h0, 0, 0, 16'h0001);
        run_seq(0, 31'h1, 0, 0, 16'h0000);
        run_seq(0, 31'h2, 0, 0, 16'h0003);

        for (int r = 0; r < 4; r++) begin
            seed = 31'($urandom);
            run_seq(0, seed, 0, 0, gold_ref(seed, 0));
        end
        seed = 31'($urandom);
        run_seq(0, seed, 0, 1, gold_ref(seed, 0));

        // Reset mid-WRITE after address 5 has been written.
        start_s[0] = 1'b1;
        cinit_s[0] = 31'($urandom);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #1;
            start_s[0] = 1'b0;
            if (wr_en_s[0] && addr_s[0] == 4'd5) found = 1;
        end
        check_val("addr5_seen", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        check_val("rst_abort", {busy_s[0], done_s[0], wr_en_s[0]}, 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (done_s[0] || wr_en_s[0]) n_done++;
        end
        check_val("rst_quiet", n_done, 0);
        run_seq(0, 31'h0, 0, 0, 16'h0001);

        // Full NC=1600 runs.
        for (int r = 0; r < 20; r++) begin
            seed = 31'($urandom);
            run_seq(1, seed, NC1, 0, gold_ref(seed, NC1));
        end
        for (int r = 0; r < 2; r++) begin
            seed = 31'($urandom);
            run_seq(1, seed, NC1, 1, gold_ref(seed, NC1));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
